resource_pool_lock: RTL
=======================

# resource_pool_lock

Arbitrated lock for a pool of identical shared execution resources (ALU units or memory ports) used by the single-instruction controllers (SICs). Each SIC raises a request tagged with its packet's issue ID, holds the granted unit until it sends a one-cycle release pulse, and the block tracks ownership per unit. It sits directly downstream of the SIC `mem_rpl`/`alu_rpl` outputs, one instance per resource class, and drives the SIC `*_grant` inputs plus the unit-select used by the datapath mux.

## Interface
- `NUM_SICS`, default 4: number of requesting SICs.
- `NUM_UNITS`, default 2: number of pooled resource units, 1..NUM_SICS.
- `ID_WIDTH`, default 4: issue-ID width; IDs wrap modulo 2^ID_WIDTH.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rpl_in` input `rpl_req#(ID_WIDTH)::t [NUM_SICS]`: per-SIC `{req, req_issue_id, release_lock}`.
- `grant` output `[NUM_SICS]`: SIC i currently holds a unit and `req` is high.
- `grant_unit` output `[NUM_SICS][$clog2(NUM_UNITS)]`: unit index held by SIC i; 0 when not holding.
- `unit_busy` output `[NUM_UNITS]`: unit u is held.
- `unit_owner` output `[NUM_UNITS][$clog2(NUM_SICS)]`: owning SIC of unit u; 0 when free.
- `err_spurious_release` output 1: sticky; set when `release_lock` arrives from a SIC holding no unit.

## Operation
- Per-unit state: FREE or HELD(owner). At reset all units are FREE. All outputs reset to 0.
- Holding flag per SIC is derived from the unit table. A SIC holds at most one unit.
- Release: when the owner's `release_lock` is high, that unit becomes FREE at the edge. `release_lock` from a non-holder sets `err_spurious_release` and is otherwise ignored.
- Hold persistence: a holder that drops `req` keeps the unit until `release_lock`. While `req` is low, `grant` is 0 but `unit_busy` stays 1.
- Candidates are SICs with `req`=1, not holding, and no `release_lock` this cycle.
- Free set = units FREE at the start of the cycle, plus units released this cycle. Released units are reusable at the same edge.
- Allocation per cycle: up to (free-set size) candidates win. The k-th winner takes the k-th lowest-index free unit.
- Winner order (age mode, see Configuration): A is older than B iff bit ID_WIDTH-1 of (A.id − B.id) mod 2^ID_WIDTH is 1. Oldest first; equal IDs resolve to the lower SIC index.
- Combinational outputs: `grant` = holding && `req`. `grant_unit`, `unit_busy`, and `unit_owner` are decoded from the registered table.

## Timing
- Request to grant: `req` rises in cycle t, unit available → `grant` high in cycle t+1. This is the minimum and it is registered.
- Release to reuse: `release_lock` in cycle t → unit FREE from cycle t+1, and a waiting candidate's `grant` is visible in cycle t+1.
- Simultaneous release and `req` from the same SIC in cycle t: the release wins. That SIC is a candidate again in cycle t+1 and its grant is seen at t+2 at the earliest.
- More candidates than free units: losers keep waiting with no starvation guarantee beyond the priority rule. Older IDs always win in age mode.
- Async reset mid-hold: all units are freed immediately and `err_spurious_release` clears. Post-reset releases from SICs that were also reset are not expected.

## Configuration
- `RPL_AGE_PRIORITY_EN` defined: winner order is by issue-ID age with wrap-around compare, as above.
- `RPL_AGE_PRIORITY_EN` undefined:
  - `req_issue_id` is ignored and winner order is round-robin from a registered pointer (reset 0).
  - Scan order is SIC index pointer, pointer+1, … mod NUM_SICS.
  - After any allocation, the pointer moves to (last winner index + 1) mod NUM_SICS; otherwise it is unchanged.

## Test plan
- Single request: SIC0 `req` with id=3 at cycle 2 → `grant[0]`=1 at cycle 3, `unit_busy`=01, `unit_owner[0]`=0. Release pulse at cycle 6 → `unit_busy`=00 at cycle 7.
- Contention, age mode, NUM_UNITS=2: SIC0..3 request with ids 5,2,7,3 in the same cycle → next cycle SIC1→unit0, SIC3→unit1. SIC1 releases → SIC0 granted unit0 in the following cycle.
- Wrap-around, age mode: SIC0 id=14, SIC1 id=1 (ID_WIDTH=4), one unit free → SIC0 wins.
- Hold without req: holder drops `req` for 3 cycles → `grant`=0 and `unit_busy`=1 throughout. A competing requester is not granted until the release pulse.
- Spurious release: SIC2 pulses `release_lock` while holding nothing → `err_spurious_release`=1 next cycle, unit table unchanged. `rst_n` low → it clears.
- Round-robin build (macro off): SIC0..3 request continuously, one unit, each releasing one cycle after grant → grant order 0,1,2,3,0.

Source files
------------

// File: rtl/resource_pool_lock_if.sv
// rtl/resource_pool_lock_if.sv - SIC-side request/grant bundle for resource_pool_lock
//
// Signals (NUM_SICS requesters, NUM_UNITS pooled units, ID_WIDTH issue IDs):
//   req                  per-SIC request
//   req_issue_id         per-SIC issue ID of the requesting packet
//   release_lock         per-SIC one-cycle release pulse
//   grant                per-SIC: holds a unit and req is high
//   grant_unit           per-SIC unit index held (0 when not holding)
//   unit_busy            per-unit held flag
//   unit_owner           per-unit owning SIC (0 when free)
//   err_spurious_release sticky: release seen from a SIC holding nothing
// Modports: master = SIC side (drives requests), slave = lock block.

interface resource_pool_lock_if #(
    parameter int NUM_SICS  = 4,
    parameter int NUM_UNITS = 2,
    parameter int ID_WIDTH  = 4
) ();
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int SW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

    logic [NUM_SICS-1:0]                req;
    logic [NUM_SICS-1:0][ID_WIDTH-1:0]  req_issue_id;
    logic [NUM_SICS-1:0]                release_lock;
    logic [NUM_SICS-1:0]                grant;
    logic [NUM_SICS-1:0][UW-1:0]        grant_unit;
    logic [NUM_UNITS-1:0]               unit_busy;
    logic [NUM_UNITS-1:0][SW-1:0]       unit_owner;
    logic                               err_spurious_release;

    modport master (
        output req, req_issue_id, release_lock,
        input  grant, grant_unit, unit_busy, unit_owner, err_spurious_release
    );

    modport slave (
        input  req, req_issue_id, release_lock,
        output grant, grant_unit, unit_busy, unit_owner, err_spurious_release
    );
endinterface

// File: rtl/resource_pool_lock.sv
// rtl/resource_pool_lock.sv - arbitrated ownership lock for a pool of identical units
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset; frees every unit and clears the error flag
//   bus    resource_pool_lock_if.slave (requests in; grants, unit table, error out)
// Build option:
//   RPL_AGE_PRIORITY_EN defined   -> winners ordered oldest issue ID first
//                                    (wrap-around compare, ties to lower SIC index)
//   RPL_AGE_PRIORITY_EN undefined -> round-robin from a registered pointer,
//                                    issue IDs ignored

module resource_pool_lock #(
    parameter int NUM_SICS  = 4,
    parameter int NUM_UNITS = 2,
    parameter int ID_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    resource_pool_lock_if.slave   bus
);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int SW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

    typedef enum logic {
        U_FREE = 1'b0,
        U_HELD = 1'b1
    } unit_state_t;

    unit_state_t                   unit_st     [NUM_UNITS];
    unit_state_t                   unit_st_nxt [NUM_UNITS];
    logic [NUM_UNITS-1:0][SW-1:0]  unit_own;
    logic [NUM_UNITS-1:0][SW-1:0]  unit_own_nxt;
    logic                          err_q;
    logic                          err_nxt;

    logic [NUM_SICS-1:0]           holding;
    logic [NUM_SICS-1:0][UW-1:0]   hold_unit;

`ifndef RPL_AGE_PRIORITY_EN
    logic [SW-1:0]                 rr_ptr;
    logic [SW-1:0]                 rr_ptr_nxt;
`endif

`ifdef RPL_AGE_PRIORITY_EN
    // A is older than B when (A - B) mod 2^ID_WIDTH has its top bit set.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a,
                                      input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction
`endif

    // Per-SIC view of the unit table; a SIC owns at most one unit.
    always_comb begin
        holding   = '0;
        hold_unit = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int i = 0; i < NUM_SICS; i++) begin
                if (unit_st[u] == U_HELD && unit_own[u] == SW'(i)) begin
                    holding[i]   = 1'b1;
                    hold_unit[i] = UW'(u);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                unit_st[u] <= U_FREE;
            end
            unit_own <= '0;
            err_q    <= 1'b0;
`ifndef RPL_AGE_PRIORITY_EN
            rr_ptr   <= '0;
`endif
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                unit_st[u] <= unit_st_nxt[u];
            end
            unit_own <= unit_own_nxt;
            err_q    <= err_nxt;
`ifndef RPL_AGE_PRIORITY_EN
            rr_ptr   <= rr_ptr_nxt;
`endif
        end
    end

    always_comb begin
        logic [NUM_SICS-1:0] remaining;
        logic                found;
        logic [SW-1:0]       best;
`ifndef RPL_AGE_PRIORITY_EN
        logic                alloc_any;
        logic [SW-1:0]       last_win;
        logic [SW-1:0]       idx;
`endif
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_st_nxt[u] = unit_st[u];
        end
        unit_own_nxt = unit_own;
        err_nxt      = err_q | (|(bus.release_lock & ~holding));
        remaining    = bus.req & ~holding & ~bus.release_lock;
        found        = 1'b0;
        best         = '0;
`ifndef RPL_AGE_PRIORITY_EN
        rr_ptr_nxt   = rr_ptr;
        alloc_any    = 1'b0;
        last_win     = '0;
        idx          = '0;
`endif

        // Owner releases first so the freed unit joins this cycle's free set.
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_st[u] == U_HELD && bus.release_lock[unit_own[u]]) begin
                unit_st_nxt[u]  = U_FREE;
                unit_own_nxt[u] = '0;
            end
        end

        // Walking units in index order hands the k-th winner the k-th lowest free unit.
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_st_nxt[u] == U_FREE) begin
                found = 1'b0;
                best  = '0;
`ifdef RPL_AGE_PRIORITY_EN
                // Strictly-older replaces, so equal IDs keep the lower index.
                for (int i = 0; i < NUM_SICS; i++) begin
                    if (remaining[i] &&
                        (!found || is_older(bus.req_issue_id[i], bus.req_issue_id[best]))) begin
                        found = 1'b1;
                        best  = SW'(i);
                    end
                end
`else
                for (int j = 0; j < NUM_SICS; j++) begin
                    idx = SW'((int'(rr_ptr) + j) % NUM_SICS);
                    if (!found && remaining[idx]) begin
                        found = 1'b1;
                        best  = idx;
                    end
                end
`endif
                if (found) begin
                    unit_st_nxt[u]  = U_HELD;
                    unit_own_nxt[u] = best;
                    remaining[best] = 1'b0;
`ifndef RPL_AGE_PRIORITY_EN
                    alloc_any       = 1'b1;
                    last_win        = best;
`endif
                end
            end
        end

`ifndef RPL_AGE_PRIORITY_EN
        if (alloc_any) begin
            rr_ptr_nxt = SW'((int'(last_win) + 1) % NUM_SICS);
        end
`endif
    end

    always_comb begin
        bus.unit_busy  = '0;
        bus.unit_owner = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            bus.unit_busy[u]  = (unit_st[u] == U_HELD);
            bus.unit_owner[u] = (unit_st[u] == U_HELD) ? unit_own[u] : '0;
        end
    end

    assign bus.grant                = holding & bus.req;
    assign bus.grant_unit           = hold_unit;
    assign bus.err_spurious_release = err_q;

endmodule
